// File: rtl/s9234_tap_pkg.sv
// s9234_tap_pkg
//  Shared types for the s9234 TAP controller.
//  - tap_state_t : 16 TAP states. The encoding follows the conventional 1149.1 state codes, so a
//                  4-bit state value read off a debug probe matches the usual reference tables.
//  - OP_*        : 3-bit instruction opcodes. Wider IRs compare against these zero-extended.
//  - chain_sel_t : which data register sits between TDI and TDO during SHIFT_DR.
package s9234_tap_pkg;

   typedef enum logic [3:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PAU_DR = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PAU_IR = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_t;

   localparam logic [2:0] OP_EXTEST = 3'b000;
   localparam logic [2:0] OP_SAMPLE = 3'b001;
   localparam logic [2:0] OP_INTEST = 3'b010;
   localparam logic [2:0] OP_SCAN   = 3'b011;
   localparam logic [2:0] OP_IDCODE = 3'b110;
   localparam logic [2:0] OP_BYPASS = 3'b111;

   typedef enum logic [1:0] {
      SEL_BSR = 2'd0,
      SEL_ISR = 2'd1,
      SEL_BYP = 2'd2,
      SEL_IDC = 2'd3
   } chain_sel_t;

endpackage

// File: rtl/s9234_tap_fsm.sv
// s9234_tap_fsm
//  16-state TAP state machine: TMS next-state logic plus the state register, nothing else.
//  Ports:
//   clk        TCK, rising edge
//   rst_n      asynchronous active-low reset (forces TLR)
//   tms        mode select
//   state      current state (registered)
//   next_state state the FSM enters on the next rising edge; the top registers its control
//              decodes from this so the controls line up with the state they belong to
module s9234_tap_fsm
   import s9234_tap_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tms,
   output tap_state_t state,
   output tap_state_t next_state
);

   tap_state_t state_reg;

   always_comb begin
      next_state = state_reg;
      case (state_reg)
         TLR:     next_state = tms ? TLR    : RTI;
         RTI:     next_state = tms ? SEL_DR : RTI;
         SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
         CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
         SH_DR:   next_state = tms ? EX1_DR : SH_DR;
         EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
         PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
         EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
         UPD_DR:  next_state = tms ? SEL_DR : RTI;
         SEL_IR:  next_state = tms ? TLR    : CAP_IR;
         CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
         SH_IR:   next_state = tms ? EX1_IR : SH_IR;
         EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
         PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
         EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
         UPD_IR:  next_state = tms ? SEL_DR : RTI;
         default: next_state = TLR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= TLR;
      else        state_reg <= next_state;
   end

   assign state = state_reg;

endmodule

// File: rtl/s9234_tap_ctrl.sv
// s9234_tap_ctrl
//  TAP controller and instruction decoder for the s9234 boundary-scan wrapper.
//  Holds the instruction register, bypass register and (optionally) the IDCODE register, decodes the
//  active instruction into BSR / internal-scan control strobes, and muxes the selected chain onto TDO.
//  Optional feature macro: S9234_TAP_IDCODE_EN
//   defined   -> 32-bit IDCODE register, opcode 110 selects it, reset instruction is IDCODE.
//                The IDCODE_VAL parameter exists only in this build.
//   undefined -> no IDCODE register, 110 behaves as BYPASS, reset instruction is BYPASS.
//  Ports:
//   CK, TRST_N           TCK and asynchronous active-low test reset
//   TMS, TDI             JTAG mode select / serial in
//   TDO_BSR, TDO_ISR     serial outputs of the boundary and internal scan chains
//   TDO, TDO_OE          serial out and its enable, both updated on falling CK
//   clockdr, shiftdr, updatedr, bs_en         boundary-scan chain controls
//   clockdr_is, shiftdr_is, updatedr_is       internal-scan chain controls
module s9234_tap_ctrl
   import s9234_tap_pkg::*;
#(
   parameter int IR_W = 3
`ifdef S9234_TAP_IDCODE_EN
   , parameter logic [31:0] IDCODE_VAL = 32'h0923_4001
`endif
)(
   input  logic CK,
   input  logic TRST_N,
   input  logic TMS,
   input  logic TDI,
   input  logic TDO_BSR,
   input  logic TDO_ISR,
   output logic TDO,
   output logic TDO_OE,
   output logic clockdr,
   output logic shiftdr,
   output logic updatedr,
   output logic bs_en,
   output logic clockdr_is,
   output logic shiftdr_is,
   output logic updatedr_is
);

   localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);
`ifdef S9234_TAP_IDCODE_EN
   localparam logic [IR_W-1:0] IR_RESET = IR_W'(OP_IDCODE);
`else
   localparam logic [IR_W-1:0] IR_RESET = IR_W'(OP_BYPASS);
`endif

   // Unused and reserved opcodes fall through to BYPASS so an unknown
   // instruction never disturbs either scan chain.
   function automatic chain_sel_t decode_sel(input logic [IR_W-1:0] ir);
      case (ir)
         IR_W'(OP_EXTEST), IR_W'(OP_SAMPLE), IR_W'(OP_INTEST): decode_sel = SEL_BSR;
         IR_W'(OP_SCAN):   decode_sel = SEL_ISR;
`ifdef S9234_TAP_IDCODE_EN
         IR_W'(OP_IDCODE): decode_sel = SEL_IDC;
`else
         IR_W'(OP_IDCODE): decode_sel = SEL_BYP;
`endif
         IR_W'(OP_BYPASS): decode_sel = SEL_BYP;
         default:          decode_sel = SEL_BYP;
      endcase
   endfunction

   tap_state_t       state;
   tap_state_t       next_state;
   logic [IR_W-1:0]  ir_shift_reg;
   logic [IR_W-1:0]  ir_active_reg;
   logic [IR_W-1:0]  ir_active_next;
   chain_sel_t       sel_cur;
   chain_sel_t       sel_next;
   logic             bypass_reg;
   logic             clockdr_reg, shiftdr_reg, updatedr_reg, bs_en_reg;
   logic             clockdr_is_reg, shiftdr_is_reg, updatedr_is_reg;
   logic             tdo_reg, tdo_oe_reg;
   logic             tdo_next, tdo_oe_next;

   s9234_tap_fsm u_fsm (
      .clk        (CK),
      .rst_n      (TRST_N),
      .tms        (TMS),
      .state      (state),
      .next_state (next_state)
   );

   // The active IR follows the state the FSM is about to enter: it is already
   // the reset instruction while in TLR, and takes the shifted value on the
   // edge that leaves UPD_IR.
   always_comb begin
      ir_active_next = ir_active_reg;
      if (next_state == TLR)   ir_active_next = IR_RESET;
      else if (state == UPD_IR) ir_active_next = ir_shift_reg;
   end

   assign sel_cur  = decode_sel(ir_active_reg);
   assign sel_next = decode_sel(ir_active_next);

   always_ff @(posedge CK or negedge TRST_N) begin
      if (!TRST_N) begin
         ir_shift_reg    <= '0;
         ir_active_reg   <= IR_RESET;
         bypass_reg      <= 1'b0;
         clockdr_reg     <= 1'b0;
         shiftdr_reg     <= 1'b0;
         updatedr_reg    <= 1'b0;
         bs_en_reg       <= 1'b0;
         clockdr_is_reg  <= 1'b0;
         shiftdr_is_reg  <= 1'b0;
         updatedr_is_reg <= 1'b0;
      end else begin
         ir_active_reg <= ir_active_next;

         if (state == CAP_IR)     ir_shift_reg <= IR_CAPTURE;
         else if (state == SH_IR) ir_shift_reg <= {TDI, ir_shift_reg[IR_W-1:1]};

         if (state == CAP_DR)                          bypass_reg <= 1'b0;
         else if (state == SH_DR && sel_cur == SEL_BYP) bypass_reg <= TDI;

         // Decoded from next_state so each strobe is high during the state it belongs to.
         clockdr_reg     <= (sel_next == SEL_BSR) && (next_state == CAP_DR || next_state == SH_DR);
         shiftdr_reg     <= (sel_next == SEL_BSR) && (next_state == SH_DR);
         updatedr_reg    <= (sel_next == SEL_BSR) && (next_state == UPD_DR);
         clockdr_is_reg  <= (sel_next == SEL_ISR) && (next_state == CAP_DR || next_state == SH_DR);
         shiftdr_is_reg  <= (sel_next == SEL_ISR) && (next_state == SH_DR);
         updatedr_is_reg <= (sel_next == SEL_ISR) && (next_state == UPD_DR);
         bs_en_reg       <= (ir_active_next == IR_W'(OP_EXTEST)) || (ir_active_next == IR_W'(OP_INTEST));
      end
   end

`ifdef S9234_TAP_IDCODE_EN
   logic [31:0] idcode_reg;

   always_ff @(posedge CK or negedge TRST_N) begin
      if (!TRST_N)                                 idcode_reg <= IDCODE_VAL;
      else if (state == CAP_DR && sel_cur == SEL_IDC) idcode_reg <= IDCODE_VAL;
      else if (state == SH_DR && sel_cur == SEL_IDC)  idcode_reg <= {TDI, idcode_reg[31:1]};
   end
`endif

   always_comb begin
      tdo_next    = 1'b0;
      tdo_oe_next = 1'b0;
      case (state)
         SH_IR: begin
            tdo_next    = ir_shift_reg[0];
            tdo_oe_next = 1'b1;
         end
         SH_DR: begin
            tdo_oe_next = 1'b1;
            case (sel_cur)
               SEL_BSR: tdo_next = TDO_BSR;
               SEL_ISR: tdo_next = TDO_ISR;
`ifdef S9234_TAP_IDCODE_EN
               SEL_IDC: tdo_next = idcode_reg[0];
`endif
               default: tdo_next = bypass_reg;
            endcase
         end
         default: ;
      endcase
   end

   // TDO launches on the falling edge so the downstream device samples it
   // half a cycle later on its rising edge.
   always_ff @(negedge CK or negedge TRST_N) begin
      if (!TRST_N) begin
         tdo_reg    <= 1'b0;
         tdo_oe_reg <= 1'b0;
      end else begin
         tdo_reg    <= tdo_next;
         tdo_oe_reg <= tdo_oe_next;
      end
   end

   assign TDO         = tdo_reg;
   assign TDO_OE      = tdo_oe_reg;
   assign clockdr     = clockdr_reg;
   assign shiftdr     = shiftdr_reg;
   assign updatedr    = updatedr_reg;
   assign bs_en       = bs_en_reg;
   assign clockdr_is  = clockdr_is_reg;
   assign shiftdr_is  = shiftdr_is_reg;
   assign updatedr_is = updatedr_is_reg;

endmodule

// File: tb/tb_s9234_tap_ctrl.sv
// tb_s9234_tap_ctrl
//  Directed bench for s9234_tap_ctrl. The stimulus side walks the TAP through reset, IR loads and
//  DR scans and, for every cycle it drives, queues the expected output vector
//  {TDO_OE,TDO,clockdr,shiftdr,updatedr,bs_en,clockdr_is,shiftdr_is,updatedr_is}.
//  A free-running monitor samples the outputs late in each cycle and retires queued expectations.
module tb_s9234_tap_ctrl;

   logic CK      = 1'b0;
   logic TRST_N  = 1'b0;
   logic TMS     = 1'b1;
   logic TDI     = 1'b0;
   logic TDO_BSR = 1'b0;
   logic TDO_ISR = 1'b0;
   logic TDO, TDO_OE, clockdr, shiftdr, updatedr, bs_en, clockdr_is, shiftdr_is, updatedr_is;

   s9234_tap_ctrl dut (
      .CK          (CK),
      .TRST_N      (TRST_N),
      .TMS         (TMS),
      .TDI         (TDI),
      .TDO_BSR     (TDO_BSR),
      .TDO_ISR     (TDO_ISR),
      .TDO         (TDO),
      .TDO_OE      (TDO_OE),
      .clockdr     (clockdr),
      .shiftdr     (shiftdr),
      .updatedr    (updatedr),
      .bs_en       (bs_en),
      .clockdr_is  (clockdr_is),
      .shiftdr_is  (shiftdr_is),
      .updatedr_is (updatedr_is)
   );

   always #5 CK = ~CK;

   localparam int K_BSR = 0;
   localparam int K_ISR = 1;
   localparam int K_BYP = 2;
   localparam int K_IDC = 3;
`ifdef S9234_TAP_IDCODE_EN
   localparam int RST_KIND = K_IDC;
   localparam int RST_LEN  = 32;
`else
   localparam int RST_KIND = K_BYP;
   localparam int RST_LEN  = 5;
`endif

   typedef struct {
      int         cyc;
      logic [8:0] exp;
      string      name;
   } exp_t;

   exp_t        sb[$];
   int          cyc_cnt  = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] idcode_val = 32'h0923_4001;
   logic [71:0] chain_pat  = 72'hA5_3C96_0FF1_7E2D_48B3;

   always @(posedge CK) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [8:0] mk(input logic oe, input logic tdo, input logic cd, input logic sd,
                                     input logic ud, input logic bs, input logic cdi, input logic sdi,
                                     input logic udi);
      return {oe, tdo, cd, sd, ud, bs, cdi, sdi, udi};
   endfunction

   task automatic step(input logic tms, input logic tdi, input logic [8:0] exp, input string name);
      exp_t e;
      e.cyc  = cyc_cnt;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      TMS = tms;
      TDI = tdi;
      @(posedge CK);
      #1;
   endtask

   task automatic ir_scan(input logic [2:0] op, input logic bs0, input logic bs1, input string tag);
      step(1'b1, 1'b0, mk(0,0,0,0,0,bs0,0,0,0), {tag, "_rti"});
      step(1'b1, 1'b0, mk(0,0,0,0,0,bs0,0,0,0), {tag, "_seldr"});
      step(1'b0, 1'b0, mk(0,0,0,0,0,bs0,0,0,0), {tag, "_selir"});
      step(1'b0, 1'b0, mk(0,0,0,0,0,bs0,0,0,0), {tag, "_capir"});
      for (int i = 0; i < 3; i++)
         step(i == 2, op[i], mk(1, i == 0, 0,0,0,bs0,0,0,0), {tag, "_shir"});
      step(1'b1, 1'b0, mk(0,0,0,0,0,bs0,0,0,0), {tag, "_ex1ir"});
      step(1'b0, 1'b0, mk(0,0,0,0,0,bs0,0,0,0), {tag, "_updir"});
      step(1'b0, 1'b0, mk(0,0,0,0,0,bs1,0,0,0), {tag, "_rti_new"});
   endtask

   task automatic dr_scan(input int kind, input int n, input logic [7:0] pat, input logic bs,
                          input string tag);
      logic cd, cdi, t, prev_tdi, exp_tdo;
      cd  = (kind == K_BSR);
      cdi = (kind == K_ISR);
      step(1'b1, 1'b0, mk(0,0,0,0,0,bs,0,0,0), {tag, "_rti"});
      step(1'b0, 1'b0, mk(0,0,0,0,0,bs,0,0,0), {tag, "_seldr"});
      step(1'b0, 1'b0, mk(0,0,cd,0,0,bs,cdi,0,0), {tag, "_capdr"});
      prev_tdi = 1'b0;
      for (int i = 0; i < n; i++) begin
         t       = pat[i % 8];
         TDO_BSR = chain_pat[i];
         TDO_ISR = ~chain_pat[i];
         case (kind)
            K_BSR:   exp_tdo = chain_pat[i];
            K_ISR:   exp_tdo = ~chain_pat[i];
            K_IDC:   exp_tdo = idcode_val[i];
            default: exp_tdo = prev_tdi;
         endcase
         step(i == n - 1, t, mk(1, exp_tdo, cd, cd, 0, bs, cdi, cdi, 0), {tag, "_shdr"});
         prev_tdi = t;
      end
      step(1'b1, 1'b0, mk(0,0,0,0,0,bs,0,0,0), {tag, "_ex1dr"});
      step(1'b0, 1'b0, mk(0,0,0,0,cd,bs,0,0,cdi), {tag, "_upddr"});
      step(1'b0, 1'b0, mk(0,0,0,0,0,bs,0,0,0), {tag, "_rti_after"});
   endtask

   initial begin : monitor
      logic [8:0] obs;
      exp_t       e;
      forever begin
         @(negedge CK);
         #3;
         obs = {TDO_OE, TDO, clockdr, shiftdr, updatedr, bs_en, clockdr_is, shiftdr_is, updatedr_is};
         while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc_cnt || obs !== e.exp) begin
               n_errors++;
               $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, e.cyc, obs, e.exp);
            end else begin
               $display("ok   %s cyc=%0d got=%b", e.name, e.cyc, obs);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      exp_t e;
      @(posedge CK);
      #1;
      step(1'b1, 1'b0, 9'h000, "reset0");
      step(1'b1, 1'b0, 9'h000, "reset1");
      TRST_N = 1'b1;
      step(1'b0, 1'b0, 9'h000, "tlr");

      dr_scan(RST_KIND, RST_LEN, 8'h0D, 1'b0, "rst_instr");
      ir_scan(3'b000, 1'b0, 1'b1, "ld_extest");
      dr_scan(K_BSR, 72, 8'h5A, 1'b1, "extest72");
      ir_scan(3'b011, 1'b1, 1'b0, "ld_scan");
      dr_scan(K_ISR, 6, 8'h33, 1'b0, "scan");
      ir_scan(3'b111, 1'b0, 1'b0, "ld_bypass");
      dr_scan(K_BYP, 5, 8'h0D, 1'b0, "bypass");
      ir_scan(3'b101, 1'b0, 1'b0, "ld_rsvd");
      dr_scan(K_BYP, 5, 8'h0D, 1'b0, "rsvd");
      ir_scan(3'b110, 1'b0, 1'b0, "ld_idcode");
      dr_scan(RST_KIND, RST_LEN, 8'h0D, 1'b0, "idcode");
      ir_scan(3'b010, 1'b0, 1'b1, "ld_intest");
      ir_scan(3'b001, 1'b1, 1'b0, "ld_sample");
      dr_scan(K_BSR, 4, 8'h09, 1'b0, "sample");

      ir_scan(3'b000, 1'b0, 1'b1, "ld_extest2");
      step(1'b1, 1'b0, mk(0,0,0,0,0,1,0,0,0), "pre_rti");
      step(1'b0, 1'b0, mk(0,0,0,0,0,1,0,0,0), "pre_seldr");
      step(1'b0, 1'b0, mk(0,0,1,0,0,1,0,0,0), "pre_capdr");
      TDO_BSR = 1'b1;
      step(1'b0, 1'b1, mk(1,1,1,1,0,1,0,0,0), "pre_shdr");
      TRST_N = 1'b0;
      step(1'b1, 1'b0, 9'h000, "trst_shdr");
      step(1'b1, 1'b0, 9'h000, "trst_hold");
      TRST_N = 1'b1;
      step(1'b0, 1'b0, 9'h000, "tlr_post");
      dr_scan(RST_KIND, RST_LEN, 8'h0D, 1'b0, "post_trst");

      repeat (2) @(posedge CK);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         n_errors++;
         if (e.cyc < cyc_cnt)
            $display("FAIL %s cyc=%0d got=unsampled exp=%b (stale)", e.name, e.cyc, e.exp);
         else
            $display("FAIL %s cyc=%0d got=unsampled exp=%b", e.name, e.cyc, e.exp);
      end
      if (n_checks < 12) begin
         n_errors++;
         $display("FAIL too few checks: %0d", n_checks);
      end
      if (n_errors == 0)
         $display("PASS Result: errors=%0d of %0d checks", n_errors, n_checks);
      else
         $display("FAIL Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
